// File: rtl/binary_run_encoder_if.sv
// Run-record stream from binary_run_encoder to the blob/centroid accumulator.
// The master presents the FIFO head; the slave accepts it with runReady.
interface binary_run_encoder_if #(
   parameter int unsigned COL_W = 10,
   parameter int unsigned ROW_W = 9
);
   logic             runValid;
   logic             runReady;
   logic [ROW_W-1:0] runRow;
   logic [COL_W-1:0] runStart;
   logic [COL_W-1:0] runEnd;
   logic             runFrameEnd;

   modport master (
      output runValid, runRow, runStart, runEnd, runFrameEnd,
      input  runReady
   );

   modport slave (
      input  runValid, runRow, runStart, runEnd, runFrameEnd,
      output runReady
   );
endinterface

// File: rtl/binary_run_encoder.sv
// Converts the binarized pixel stream into (row, start, end) foreground run records
// held in a small FWFT FIFO. Define FRAME_MARKER_EN to also queue a marker per vsync rise.
module binary_run_encoder #(
   parameter int unsigned COL_W      = 10,
   parameter int unsigned ROW_W      = 9,
   parameter int unsigned MIN_RUN    = 1,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic                 pclk,
   input  logic                 reset,
   input  logic                 bin,
   input  logic                 valid,
   input  logic                 hrefBin,
   input  logic                 vsyncBin,
   binary_run_encoder_if.master run,
   output logic                 overflow
);

   localparam int unsigned      PTR_W   = $clog2(FIFO_DEPTH);
   localparam logic [COL_W-1:0] COL_MAX = '1;
   localparam logic [COL_W-1:0] COL_ONE = COL_W'(1);
   localparam logic [ROW_W-1:0] ROW_MAX = '1;
   localparam logic [ROW_W-1:0] ROW_ONE = ROW_W'(1);
   localparam logic [COL_W:0]   MIN_LEN = (COL_W+1)'(MIN_RUN);
   localparam logic [COL_W:0]   LEN_ONE = (COL_W+1)'(1);
   localparam logic [PTR_W:0]   PTR_ONE = (PTR_W+1)'(1);

   localparam logic [0:0] IDLE   = 1'b0;
   localparam logic [0:0] IN_RUN = 1'b1;

   logic             href_q, vsync_q;
   logic             href_fall, vsync_rise, pix;
   logic [COL_W-1:0] col, last_col, run_start;
   logic [ROW_W-1:0] row;
   logic [0:0]       state;

   logic             close;
   logic [COL_W-1:0] close_end;
   logic [COL_W:0]   run_len;

   logic             push;
   logic [ROW_W-1:0] push_row;
   logic [COL_W-1:0] push_start, push_end;

   logic [PTR_W:0]   wr_ptr, rd_ptr;
   logic             empty, full, pop, wr_en;

   logic [ROW_W-1:0] mem_row   [FIFO_DEPTH];
   logic [COL_W-1:0] mem_start [FIFO_DEPTH];
   logic [COL_W-1:0] mem_end   [FIFO_DEPTH];
`ifdef FRAME_MARKER_EN
   logic             push_fe;
   logic             mem_fe    [FIFO_DEPTH];
`endif

   assign href_fall  = href_q & ~hrefBin;
   assign vsync_rise = vsyncBin & ~vsync_q;
   assign pix        = valid & hrefBin;

   // Close priority: foreground ends on a background pixel, then line end, then column saturation.
   always_comb begin
      close     = 1'b0;
      close_end = '0;
      if (state == IN_RUN && !vsync_rise) begin
         if (pix && !bin) begin
            close     = 1'b1;
            close_end = col - COL_ONE;
         end else if (href_fall) begin
            close     = 1'b1;
            close_end = last_col;
         end else if (pix && col == COL_MAX) begin
            close     = 1'b1;
            close_end = COL_MAX;
         end
      end
   end

   assign run_len = {1'b0, close_end} - {1'b0, run_start} + LEN_ONE;

   always_comb begin
      push       = 1'b0;
      push_row   = row;
      push_start = run_start;
      push_end   = close_end;
      if (close && run_len >= MIN_LEN)
         push = 1'b1;
`ifdef FRAME_MARKER_EN
      push_fe = 1'b0;
      if (vsync_rise) begin
         push       = 1'b1;
         push_start = '0;
         push_end   = '0;
         push_fe    = 1'b1;
      end
`endif
   end

   always_ff @(posedge pclk or posedge reset) begin
      if (reset) begin
         href_q    <= 1'b0;
         vsync_q   <= 1'b0;
         col       <= '0;
         last_col  <= '0;
         run_start <= '0;
         row       <= '0;
         state     <= IDLE;
      end else begin
         href_q  <= hrefBin;
         vsync_q <= vsyncBin;
         if (vsync_rise) begin
            col   <= '0;
            row   <= '0;
            state <= IDLE;
         end else begin
            if (href_fall) begin
               col <= '0;
               if (row != ROW_MAX)
                  row <= row + ROW_ONE;
            end else if (pix) begin
               last_col <= col;
               if (col != COL_MAX)
                  col <= col + COL_ONE;
            end
            if (close)
               state <= IDLE;
            else if (state == IDLE && pix && bin) begin
               state     <= IN_RUN;
               run_start <= col;
            end
         end
      end
   end

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                  (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
   assign pop   = !empty && run.runReady;
   assign wr_en = push && (!full || pop);

   // A drop sets overflow after the vsync clear so a dropped marker still reports.
   always_ff @(posedge pclk or posedge reset) begin
      if (reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         overflow <= 1'b0;
      end else begin
         if (wr_en)
            wr_ptr <= wr_ptr + PTR_ONE;
         if (pop)
            rd_ptr <= rd_ptr + PTR_ONE;
         if (vsync_rise)
            overflow <= 1'b0;
         if (push && full && !pop)
            overflow <= 1'b1;
      end
   end

   always_ff @(posedge pclk) begin
      if (wr_en) begin
         mem_row[wr_ptr[PTR_W-1:0]]   <= push_row;
         mem_start[wr_ptr[PTR_W-1:0]] <= push_start;
         mem_end[wr_ptr[PTR_W-1:0]]   <= push_end;
`ifdef FRAME_MARKER_EN
         mem_fe[wr_ptr[PTR_W-1:0]]    <= push_fe;
`endif
      end
   end

   assign run.runValid = !empty;
   assign run.runRow   = empty ? '0 : mem_row[rd_ptr[PTR_W-1:0]];
   assign run.runStart = empty ? '0 : mem_start[rd_ptr[PTR_W-1:0]];
   assign run.runEnd   = empty ? '0 : mem_end[rd_ptr[PTR_W-1:0]];
`ifdef FRAME_MARKER_EN
   assign run.runFrameEnd = empty ? 1'b0 : mem_fe[rd_ptr[PTR_W-1:0]];
`else
   assign run.runFrameEnd = 1'b0;
`endif

endmodule
